// File: rtl/sram_access_arbiter.sv
// -----------------------------------------------------------------------------
// sram_access_arbiter
//
// Two-port round-robin arbiter and access sequencer in front of a single
// on-chip SRAM. One access runs at a time. The SRAM enable is held for
// ACCESS_CYCLES cycles to cover the array delay. The granted port then gets a
// one-cycle acknowledge, and read data is held in a register.
//
// Ports:
//   clk, n_rst            system clock (rising edge), async active-low reset
//   req0/wen0/addr0/wdata0  port 0 request (level), write flag, address, data
//   req1/wen1/addr1/wdata1  port 1 request (level), write flag, address, data
//   ack0, ack1            one-cycle completion pulse per port
//   rdata                 data of the last completed read
//   busy                  high while an access is in flight (state != IDLE)
//   sram_read_enable      to SRAM read_enable
//   sram_write_enable     to SRAM write_enable
//   sram_address          to SRAM address (held outside an access)
//   sram_write_data       to SRAM write_data (held outside an access)
//   sram_read_data        from SRAM read_data
// -----------------------------------------------------------------------------
module sram_access_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 128
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req0,
    input  logic              wen0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              wen1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              sram_read_enable,
    output logic              sram_write_enable,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_write_data,
    input  logic [DATA_W-1:0] sram_read_data
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  counter_q, counter_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              op_wen_q, op_wen_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              busy_q, busy_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Winner among the current requests. When both are asserted, the port
    // that was not served last wins. This gives strict alternation under
    // contention.
    logic grant_sel;
    assign grant_sel = (req0 && req1) ? ~last_grant_q : req1;

    always_comb begin
        // NOTE: every target gets a default first, so no path leaves a
        // variable unassigned and no latch is inferred.
        state_d      = state_q;
        counter_d    = counter_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        op_wen_d     = op_wen_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rd_en_d      = rd_en_q;
        wr_en_d      = wr_en_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d   = grant_sel;
                    op_wen_d  = grant_sel ? wen1   : wen0;
                    addr_d    = grant_sel ? addr1  : addr0;
                    wdata_d   = grant_sel ? wdata1 : wdata0;
                    counter_d = '0;
                    rd_en_d   = ~(grant_sel ? wen1 : wen0);
                    wr_en_d   =  (grant_sel ? wen1 : wen0);
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                counter_d = counter_q + 1'b1;
                if (counter_q == LAST_CNT) begin
                    // The SRAM has had the full window, so its read data is
                    // valid at this edge.
                    if (!op_wen_q) begin
                        rdata_d = sram_read_data;
                    end
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                    ack0_d  = ~grant_q;
                    ack1_d  =  grant_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: begin
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            counter_q    <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_wen_q     <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            op_wen_q     <= op_wen_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    assign ack0              = ack0_q;
    assign ack1              = ack1_q;
    assign rdata             = rdata_q;
    assign busy              = busy_q;
    assign sram_read_enable  = rd_en_q;
    assign sram_write_enable = wr_en_q;
    assign sram_address      = addr_q;
    assign sram_write_data   = wdata_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_access_arbiter
//
// Bench for sram_access_arbiter. The main instance uses ACCESS_CYCLES=2 and is
// checked every cycle against a transaction-level model. The model tracks one
// in-flight access as "edges since grant". A second instance with
// ACCESS_CYCLES=1 gets a short directed read/write check.
// -----------------------------------------------------------------------------
module tb_sram_access_arbiter;

    localparam int AC = 2;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- main instance (ACCESS_CYCLES = 2) ----------------
    logic         req0, wen0, req1, wen1;
    logic [15:0]  addr0, addr1;
    logic [127:0] wdata0, wdata1;
    logic         ack0, ack1, busy, sram_re, sram_we;
    logic [127:0] rdata, sram_wd, sram_rd;
    logic [15:0]  sram_addr;

    sram_access_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(16), .DATA_W(128)) dut (
        .clk(clk), .n_rst(n_rst),
        .req0(req0), .wen0(wen0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .wen1(wen1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .sram_read_enable(sram_re), .sram_write_enable(sram_we),
        .sram_address(sram_addr), .sram_write_data(sram_wd),
        .sram_read_data(sram_rd)
    );

    // SRAM stand-in: a write lands on every edge where write_enable is high.
    // Read data is visible while read_enable is high.
    bit [127:0] sram_mem [0:255];
    always @(posedge clk) if (sram_we) sram_mem[sram_addr[7:0]] <= sram_wd;
    assign sram_rd = sram_re ? sram_mem[sram_addr[7:0]] : '0;

    // ---------------- small instance (ACCESS_CYCLES = 1) ----------------
    logic         s_req0, s_wen0, s_req1, s_wen1;
    logic [15:0]  s_addr0, s_addr1;
    logic [127:0] s_wdata0, s_wdata1;
    logic         s_ack0, s_ack1, s_busy, s_re, s_we;
    logic [127:0] s_rdata, s_wd, s_rd;
    logic [15:0]  s_addr;

    sram_access_arbiter #(.ACCESS_CYCLES(1), .ADDR_W(16), .DATA_W(128)) dut1 (
        .clk(clk), .n_rst(n_rst),
        .req0(s_req0), .wen0(s_wen0), .addr0(s_addr0), .wdata0(s_wdata0),
        .req1(s_req1), .wen1(s_wen1), .addr1(s_addr1), .wdata1(s_wdata1),
        .ack0(s_ack0), .ack1(s_ack1), .rdata(s_rdata), .busy(s_busy),
        .sram_read_enable(s_re), .sram_write_enable(s_we),
        .sram_address(s_addr), .sram_write_data(s_wd),
        .sram_read_data(s_rd)
    );

    bit [127:0] s_mem [0:255];
    always @(posedge clk) if (s_we) s_mem[s_addr[7:0]] <= s_wd;
    assign s_rd = s_re ? s_mem[s_addr[7:0]] : '0;

    // ---------------- reference model ----------------
    // m_phase counts the edges since the grant edge. The enables are on for
    // phases 0..AC-1, the ack is on at phase AC, and phase AC+1 is back in
    // idle.
    bit         m_busy, m_port, m_wen, m_last;
    int         m_phase;
    bit [15:0]  m_addr;
    bit [127:0] m_wdata, m_rdata;
    bit [127:0] m_mem [0:255];

    task automatic model_reset();
        m_busy = 0; m_port = 0; m_wen = 0; m_last = 1; m_phase = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_edge();
        if (!m_busy) begin
            if (req0 || req1) begin
                m_port  = (req0 && req1) ? !m_last : req1;
                m_wen   = m_port ? wen1   : wen0;
                m_addr  = m_port ? addr1  : addr0;
                m_wdata = m_port ? wdata1 : wdata0;
                m_busy  = 1;
                m_phase = 0;
            end
        end else begin
            if (m_phase < AC && m_wen) m_mem[m_addr[7:0]] = m_wdata;
            m_phase++;
            if (m_phase == AC && !m_wen) m_rdata = m_mem[m_addr[7:0]];
            if (m_phase == AC + 1) begin
                m_busy = 0;
                m_last = m_port;
            end
        end
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic compare_all();
        bit en = m_busy && (m_phase < AC);
        bit ak = m_busy && (m_phase == AC);
        check("ack0",  128'(ack0),    128'(ak && !m_port));
        check("ack1",  128'(ack1),    128'(ak &&  m_port));
        check("busy",  128'(busy),    128'(m_busy));
        check("rd_en", 128'(sram_re), 128'(en && !m_wen));
        check("wr_en", 128'(sram_we), 128'(en &&  m_wen));
        check("addr",  128'(sram_addr), 128'(m_addr));
        check("wdata", sram_wd, m_wdata);
        check("rdata", rdata,   m_rdata);
    endtask

    // One clock: model steps with the inputs present at the edge, then the
    // DUT outputs are sampled 1 ns after the edge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    localparam logic [127:0] D0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] D1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] DS = 128'h5A5A5A5A_A5A5A5A5_0F0F0F0F_F0F0F0F0;

    initial begin
        int order[$];

        req0 = 0; wen0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; wen1 = 0; addr1 = '0; wdata1 = '0;
        s_req0 = 0; s_wen0 = 0; s_addr0 = '0; s_wdata0 = '0;
        s_req1 = 0; s_wen1 = 0; s_addr1 = '0; s_wdata1 = '0;
        n_rst = 0;
        model_reset();

        // Reset state
        #2;
        compare_all();
        #5 n_rst = 1;

        // Port 0 write to 0x0010
        req0 = 1; wen0 = 1; addr0 = 16'h0010; wdata0 = D0;
        cycle();
        req0 = 0;
        run(3);
        check("rdata_after_write", rdata, '0);

        // Port 0 read back 0x0010
        req0 = 1; wen0 = 0; addr0 = 16'h0010; wdata0 = '0;
        cycle();
        req0 = 0;
        run(2);
        check("rdata_on_ack", rdata, D0);
        run(3);
        check("rdata_held", rdata, D0);

        // Port 1 write to 0x0020. Port 1 is then served last, so port 0
        // wins the next tie.
        req1 = 1; wen1 = 1; addr1 = 16'h0020; wdata1 = D1;
        cycle();
        req1 = 0;
        run(3);

        // Contention: both ports read, requests held for 4 accesses
        req0 = 1; wen0 = 0; addr0 = 16'h0010;
        req1 = 1; wen1 = 0; addr1 = 16'h0020;
        for (int i = 0; i < 4 * (AC + 2); i++) begin
            cycle();
            if (ack0) order.push_back(0);
            if (ack1) order.push_back(1);
        end
        req0 = 0; req1 = 0;
        check("rr_count", 128'(order.size()), 128'd4);
        for (int i = 0; i < 4; i++)
            if (i < order.size()) check("rr_order", 128'(order[i]), 128'(i % 2));
        run(2);

        // Port 1 arrives while port 0 is in ACCESS and waits for idle
        req0 = 1; wen0 = 0; addr0 = 16'h0020;
        cycle();
        req0 = 0;
        req1 = 1; wen1 = 0; addr1 = 16'h0010;
        run(3);
        check("p1_waits_busy", 128'(sram_re), 128'd0);
        cycle();
        check("p1_granted", 128'(sram_re), 128'd1);
        req1 = 0;
        run(3);

        // Reset during the second ACCESS cycle of a write
        req0 = 1; wen0 = 1; addr0 = 16'h0030; wdata0 = {4{32'h1357_9BDF}};
        cycle();
        req0 = 0;
        cycle();
        n_rst = 0;
        #1;
        check("rst_wr_en", 128'(sram_we), 128'd0);
        check("rst_busy",  128'(busy),    128'd0);
        check("rst_ack0",  128'(ack0),    128'd0);
        check("rst_rdata", rdata,         '0);
        model_reset();
        compare_all();
        #1 n_rst = 1;
        run(5);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle();
            if (req0 && ack0 && $urandom_range(0, 3) != 0) req0 = 0;
            else if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1; wen0 = 1'($urandom);
                addr0 = {8'($urandom), 8'($urandom_range(0, 7))};
                wdata0 = {$urandom, $urandom, $urandom, $urandom};
            end else if (req0 && $urandom_range(0, 7) == 0) begin
                addr0 = {8'($urandom), 8'($urandom_range(0, 7))};
                wdata0 = {$urandom, $urandom, $urandom, $urandom};
            end
            if (req1 && ack1 && $urandom_range(0, 3) != 0) req1 = 0;
            else if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1; wen1 = 1'($urandom);
                addr1 = {8'($urandom), 8'($urandom_range(0, 7))};
                wdata1 = {$urandom, $urandom, $urandom, $urandom};
            end else if (req1 && $urandom_range(0, 7) == 0) begin
                addr1 = {8'($urandom), 8'($urandom_range(0, 7))};
                wdata1 = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        req0 = 0; req1 = 0;
        run(6);

        // ACCESS_CYCLES=1 instance: write then read back on port 1
        s_req1 = 1; s_wen1 = 1; s_addr1 = 16'h0042; s_wdata1 = DS;
        @(posedge clk); #1;
        s_req1 = 0;
        check("ac1_wr_en", 128'(s_we), 128'd1);
        check("ac1_addr",  128'(s_addr), 128'h0042);
        @(posedge clk); #1;
        check("ac1_wr_off", 128'(s_we),   128'd0);
        check("ac1_wr_ack", 128'(s_ack1), 128'd1);
        @(posedge clk); #1;
        check("ac1_idle", 128'(s_busy), 128'd0);
        s_req1 = 1; s_wen1 = 0; s_wdata1 = '0;
        @(posedge clk); #1;
        s_req1 = 0;
        check("ac1_rd_en",  128'(s_re),   128'd1);
        check("ac1_no_ack", 128'(s_ack1), 128'd0);
        @(posedge clk); #1;
        check("ac1_rd_off", 128'(s_re),   128'd0);
        check("ac1_rd_ack", 128'(s_ack1), 128'd1);
        check("ac1_rdata",  s_rdata,      DS);
        @(posedge clk); #1;
        check("ac1_ack_end", 128'(s_ack1), 128'd0);
        check("ac1_rdata_held", s_rdata,   DS);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
Two-port arbiter and sequencer in front of the on-chip SRAM wrapper (16-bit byte address, 128-bit / 16-byte data bus). It gives two requesters (port 0 and port 1) shared access to the single SRAM. It runs one access at a time, holds the SRAM enables for a fixed number of cycles to cover the read/write delay, and returns read data with a one-cycle acknowledge. Requesters never drive the SRAM directly.

Parameters:
ACCESS_CYCLES, 2, clock cycles the SRAM enable is held per access (must be >=1; covers 5 ns SRAM delay)
ADDR_W, 16, SRAM address width
DATA_W, 128, SRAM data width (16 words x 1 byte)

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
req0  input  1  port 0 access request (level)
wen0  input  1  port 0: 1 = write, 0 = read
addr0  input  ADDR_W  port 0 starting byte address
wdata0  input  DATA_W  port 0 write data
req1  input  1  port 1 access request (level)
wen1  input  1  port 1: 1 = write, 0 = read
addr1  input  ADDR_W  port 1 starting byte address
wdata1  input  DATA_W  port 1 write data
ack0  output  1  one-cycle pulse: port 0 access complete
ack1  output  1  one-cycle pulse: port 1 access complete
rdata  output  DATA_W  registered read data of the last completed read
busy  output  1  high whenever state != IDLE
sram_read_enable  output  1  to SRAM read_enable
sram_write_enable  output  1  to SRAM write_enable
sram_address  output  ADDR_W  to SRAM address
sram_write_data  output  DATA_W  to SRAM write_data
sram_read_data  input  DATA_W  from SRAM read_data

Behaviour:
- All outputs are registered. Reset (async, n_rst=0) sets:
  - state=IDLE, counter=0
  - ack0=ack1=0, busy=0, both SRAM enables=0
  - sram_address=0, sram_write_data=0, rdata=0
  - last_grant=1, so port 0 wins the first tie.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Sample req0/req1 each cycle.
  - Only one asserted: grant that port.
  - Both asserted: grant the port != last_grant (round-robin).
  - On grant, latch grant id, wen, addr and wdata of the granted port into sram_address / sram_write_data / op register. Set counter=0 and go to ACCESS.
  - No request: stay in IDLE with enables low.
- ACCESS:
  - sram_read_enable = !op_wen and sram_write_enable = op_wen, held for exactly ACCESS_CYCLES cycles.
  - Address and write data are stable for the whole window.
  - Counter increments each cycle.
  - On the cycle where counter == ACCESS_CYCLES-1, and the op is a read, capture sram_read_data into rdata at that edge. Go to DONE.
- DONE:
  - Both enables low.
  - ack of the granted port high for exactly this one cycle.
  - last_grant <= grant id. Go to IDLE.
- Latency: request seen in IDLE at edge 0 → enables high for cycles 1..ACCESS_CYCLES → ack at cycle ACCESS_CYCLES+1. Default is 3 cycles from request to ack.
- Back-to-back access spacing is ACCESS_CYCLES+2 cycles.
- rdata is valid when the ack for a read is high, and holds until the next read completes. Writes never change rdata.
- sram_address and sram_write_data hold their last latched values outside ACCESS.
- sram_read_enable and sram_write_enable are never both high.
- Request inputs are ignored outside IDLE. Changes to a waiting port's addr/wdata before its grant are honoured; changes after the latch are not.
- A requester that still holds req in the cycle after its ack is treated as issuing a new request. Requesters deassert req on seeing ack to avoid a repeat access.
- Round-robin rule: under continuous contention the ports alternate strictly 0,1,0,1.
- Reset mid-ACCESS or mid-DONE:
  - Enables and ack drop immediately (asynchronous).
  - The in-flight access is abandoned, with no ack.
  - rdata returns to 0.
- Address arithmetic: passed through unmodified; no alignment or range check (the SRAM wrapper handles 16-byte bursts from any start address).

Test Plan:
- Reset, then port 0 writes addr=0x0010, wdata=0x00112233_44556677_8899AABB_CCDDEEFF → sram_write_enable high for 2 cycles with that addr/data, ack0 pulses 3 cycles after req, rdata stays 0.
- Port 0 reads 0x0010 after that write → sram_read_enable high for 2 cycles, ack0 pulse, rdata = 0x00112233_44556677_8899AABB_CCDDEEFF on the ack cycle and held afterwards.
- req0 and req1 asserted together and held 4 accesses, both reading different addresses → grant order 0,1,0,1, acks 4 cycles apart, one ack high per pulse, never both.
- Port 1 requests while port 0 is in ACCESS → port 1 is not granted until IDLE after ack0; port 1's enables start the cycle after it is sampled in IDLE.
- Assert n_rst=0 during the second ACCESS cycle of a write → enables, busy and ack go 0 immediately. After release with no req, busy stays 0 and no ack occurs.
- ACCESS_CYCLES=1 build: single read → enable high 1 cycle, ack 2 cycles after req, rdata captured correctly.
